// File: rtl/mult16_seq_pkg.sv
// Shared definitions for the mult16_seq shift-add multiplier.
package mult16_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int STEPS  = 16;
  localparam int PROD_W = 32;

endpackage

// File: rtl/fulladder16.sv
// 16-bit ripple-carry adder; the only adder used by mult16_seq.
module fulladder16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CI,
  output logic [15:0] SUM,
  output logic        CO
);

  logic carry_s;

  // Ripple the carry through the 16 bit positions.
  always_comb begin
    carry_s = CI;
    SUM     = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      SUM[i]  = A[i] ^ B[i] ^ carry_s;
      carry_s = (A[i] & B[i]) | (carry_s & (A[i] ^ B[i]));
    end
    CO = carry_s;
  end

endmodule

// File: rtl/mult16_seq.sv
// Iterative unsigned 16x16->32 shift-add multiplier with valid/ready handshakes.
// Optional early termination on exhausted multiplier bits: MULT16_EARLY_TERM_EN.
module mult16_seq
  import mult16_seq_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       a,
  input  logic [15:0]       b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
);

  state_e             state_q, state_d;
  logic [15:0]        mcand_q, mcand_d;
  logic [15:0]        hi_q, hi_d;
  logic [15:0]        lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [15:0]        add_b_s;
  logic [15:0]        sum_s;
  logic               co_s;

  assign add_b_s = lo_q[0] ? mcand_q : 16'h0000;

  fulladder16 u_step_adder (
    .A   (hi_q),
    .B   (add_b_s),
    .CI  (1'b0),
    .SUM (sum_s),
    .CO  (co_s)
  );

`ifdef MULT16_EARLY_TERM_EN
  logic [15:0]        rem_mask_s;
  logic [CNT_W-1:0]   shamt_s;

  // Low (16-cnt) bits of lo still hold unconsumed multiplier bits.
  assign rem_mask_s = 16'hFFFF >> cnt_q;
  assign shamt_s    = CNT_W'(STEPS) - cnt_q;
`endif

  // Next-state logic for the control FSM and the hi/lo/mcand datapath.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = a;
          hi_d    = 16'h0000;
          lo_d    = b;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef MULT16_EARLY_TERM_EN
        if ((lo_q & rem_mask_s) == 16'h0000) begin
          {hi_d, lo_d} = {hi_q, lo_q} >> shamt_s;
          state_d      = DONE;
        end else begin
          {hi_d, lo_d} = {co_s, sum_s, lo_q[15:1]};
          if (cnt_q == CNT_W'(STEPS - 1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
`else
        {hi_d, lo_d} = {co_s, sum_s, lo_q[15:1]};
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= 16'h0000;
      hi_q    <= 16'h0000;
      lo_q    <= 16'h0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = {hi_q, lo_q};

endmodule

// File: tb/tb_mult16_seq.sv
// Directed and randomised self-checking bench for mult16_seq.
module tb_mult16_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  int tests_run;
  int tests_failed;

  mult16_seq #(.CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [15:0] bb);
`ifdef MULT16_EARLY_TERM_EN
    int m;
    if (bb == 16'h0000) return 1;
    m = 0;
    for (int i = 0; i < 16; i++) if (bb[i]) m = i;
    return (m + 2 > 16) ? 16 : m + 2;
`else
    return 16;
`endif
  endfunction

  // Drives one operation; keeps in_valid high with junk operands while busy.
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b, input int bp,
                        output int lat, output logic [31:0] prod, output bit held);
    int n;
    logic [31:0] p0;
    held = 1'b1;
    lat  = -1;
    @(negedge clk);
    a = op_a; b = op_b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 16'($urandom); b = 16'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (out_valid) lat = n;
    prod = product;
    p0   = product;
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      if (product !== p0 || out_valid !== 1'b1 || in_ready !== 1'b0) held = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b product=%h expected 1 0 00000000",
               in_ready, out_valid, product);
    end
    rst = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [15:0] op_a, input logic [15:0] op_b,
                          input logic [31:0] exp_p, input int bp);
    int lat;
    logic [31:0] prod;
    bit held;
    run_op(op_a, op_b, bp, lat, prod, held);
    tests_run++;
    if (prod !== exp_p) begin
      tests_failed++;
      $display("FAIL %s_product: got %h expected %h", name, prod, exp_p);
    end
    tests_run++;
    if (lat !== exp_lat(op_b)) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat(op_b));
    end
    tests_run++;
    if (held !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_held: got %b expected 1", name, held);
    end
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle_after: got in_ready=%b out_valid=%b expected 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    check_op("basic_3x5", 16'd3, 16'd5, 32'h0000000F, 0);
    check_op("zero_a", 16'h0000, 16'h1234, 32'h00000000, 1);
  endtask

  task automatic test_carry();
    check_op("ffff_sq", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0);
    check_op("8000x2", 16'h8000, 16'h0002, 32'h00010000, 2);
  endtask

  task automatic test_backpressure();
    check_op("bp_1234x5678", 16'h1234, 16'h5678, 32'h06260060, 10);
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    a = 16'hABCD; b = 16'h00FF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_midop: got in_ready=%b out_valid=%b product=%h expected 1 0 00000000",
               in_ready, out_valid, product);
    end
    @(negedge clk);
    rst = 1'b0;
    check_op("after_rst_2x2", 16'd2, 16'd2, 32'h00000004, 0);
  endtask

  task automatic test_early_term();
    check_op("b1_aff", 16'h00FF, 16'h0001, 32'h000000FF, 0);
    check_op("b0", 16'h5555, 16'h0000, 32'h00000000, 0);
    check_op("b8000", 16'h0003, 16'h8000, 32'h00018000, 0);
  endtask

  task automatic test_random();
    logic [15:0] ra, rb;
    logic [31:0] ep;
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 7 == 0) rb = rb >> (i % 16);
      ep = {16'h0000, ra} * {16'h0000, rb};
      check_op("random", ra, rb, ep, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_midop();
    test_early_term();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
